// File: rtl/sr_latch_ctrl.sv
// Sequencer/arbiter for one external S-R latch: round-robin set/reset requests,
// width-controlled S/R pulses, and a post-pulse feedback check with sticky error.
//
// state  | meaning
// IDLE   | waiting for a request, ready to a granted requester
// PULSE  | driving S or R for PULSE_W cycles
// SETTLE | all-low, latch feedback checked on the last cycle
// GAP    | all-low guard before the next command
module sr_latch_ctrl #(
    parameter int PULSE_W  = 2,
    parameter int SETTLE_W = 3,
    parameter int GAP_W    = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_a_valid,
    input  logic req_a_op,
    output logic req_a_ready,
    input  logic req_b_valid,
    input  logic req_b_op,
    output logic req_b_ready,
    input  logic latch_q,
    input  logic latch_q_not,
    output logic s_out,
    output logic r_out,
    output logic busy,
    output logic state_exp,
    output logic err_mismatch,
    input  logic err_clr
);

    localparam int CW = $clog2(PULSE_W + SETTLE_W + GAP_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PULSE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_op;
    logic          r_last_b;
    logic          r_s_out;
    logic          r_r_out;
    logic          r_state_exp;
    logic          r_err;
    logic          r_q_s1;
    logic          r_q_s2;
    logic          r_qn_s1;
    logic          r_qn_s2;

    logic          w_idle;
    logic          w_grant_a;
    logic          w_grant_b;
    logic          w_xfer;
    logic          w_op_sel;
    logic          w_cnt_tc;
    logic          w_s_nxt;
    logic          w_r_nxt;
    logic          w_check;
    logic          w_mismatch;

    // r_last_b=1 after reset so that A wins the first contended grant
    always_comb begin
        w_idle     = (r_state == ST_IDLE);
        w_grant_a  = req_a_valid & (~req_b_valid | r_last_b);
        w_grant_b  = req_b_valid & (~req_a_valid | ~r_last_b);
        w_xfer     = w_idle & (w_grant_a | w_grant_b);
        w_op_sel   = w_grant_a ? req_a_op : req_b_op;
        w_cnt_tc   = (r_cnt == '0);
        w_check    = (r_state == ST_SETTLE) & w_cnt_tc;
        w_mismatch = w_check & ((r_q_s2 != r_op) | (r_qn_s2 != ~r_op));
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_s_nxt     = 1'b0;
        w_r_nxt     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    w_state_nxt = ST_PULSE;
                    w_cnt_nxt   = CW'(PULSE_W - 1);
                    w_s_nxt     = w_op_sel;
                    w_r_nxt     = ~w_op_sel;
                end
            end
            ST_PULSE: begin
                if (w_cnt_tc) begin
                    w_state_nxt = ST_SETTLE;
                    w_cnt_nxt   = CW'(SETTLE_W - 1);
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                    w_s_nxt     = r_op;
                    w_r_nxt     = ~r_op;
                end
            end
            ST_SETTLE: begin
                if (w_cnt_tc) begin
                    w_state_nxt = ST_GAP;
                    w_cnt_nxt   = CW'(GAP_W - 1);
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            ST_GAP: begin
                if (w_cnt_tc) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_op        <= 1'b0;
            r_last_b    <= 1'b1;
            r_s_out     <= 1'b0;
            r_r_out     <= 1'b0;
            r_state_exp <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_s_out <= w_s_nxt;
            r_r_out <= w_r_nxt;
            if (w_xfer) begin
                r_op     <= w_op_sel;
                r_last_b <= w_grant_b;
            end
            if ((r_state == ST_PULSE) && w_cnt_tc) begin
                r_state_exp <= r_op;
            end
            // a fresh mismatch overrides a simultaneous clear
            r_err <= w_mismatch | (r_err & ~err_clr);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q_s1  <= 1'b0;
            r_q_s2  <= 1'b0;
            r_qn_s1 <= 1'b0;
            r_qn_s2 <= 1'b0;
        end else begin
            r_q_s1  <= latch_q;
            r_q_s2  <= r_q_s1;
            r_qn_s1 <= latch_q_not;
            r_qn_s2 <= r_qn_s1;
        end
    end

    assign req_a_ready  = w_idle & w_grant_a;
    assign req_b_ready  = w_idle & w_grant_b;
    assign s_out        = r_s_out;
    assign r_out        = r_r_out;
    assign busy         = ~w_idle;
    assign state_exp    = r_state_exp;
    assign err_mismatch = r_err;

endmodule
